// File: rtl/apb_slave_if.sv
// APB bus signals between the peripheral-side completer and its requester.
// Clock and reset stay outside the interface as plain ports.
interface apb_slave_if;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave.sv
// APB completer with a register bank, byte strobes, read-only ID and error responses.
// Define APB_SLAVE_WAIT_EN to compile in the WAIT state and its WAIT_CYCLES countdown.
module apb_slave #(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input logic        PCLK,
  input logic        PRESETn,
  apb_slave_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_REGS);

`ifdef APB_SLAVE_WAIT_EN
  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;
  logic [3:0] r_cnt;
`else
  typedef enum logic [0:0] {StIdle, StReady} state_e;
  logic w_unused_wait;
  assign w_unused_wait = |WAIT_CYCLES;
`endif

  state_e          r_state;
  logic [31:0]     r_regs [NUM_REGS];
  logic [31:0]     r_prdata;
  logic            r_pready;
  logic            r_pslverr;

  logic [31:0]     w_offset;
  logic            w_in_range;
  logic            w_aligned;
  logic [IdxW-1:0] w_index;
  logic            w_is_id;
  logic            w_err;
  logic [31:0]     w_rdata;

  // Decode from the live bus; APB holds address and control stable for the whole transfer.
  always_comb begin
    w_offset   = bus.PADDR - BASE_ADDR;
    w_aligned  = (bus.PADDR[1:0] == 2'b00);
    w_in_range = (w_offset < 32'(NUM_REGS * 4));
    w_index    = w_offset[IdxW+1:2];
    w_is_id    = (w_index == IdxW'(NUM_REGS - 1));
    w_err      = !w_aligned || !w_in_range || (bus.PWRITE && w_is_id);
    w_rdata    = 32'h0;
    if (!w_err && !bus.PWRITE) begin
      w_rdata = w_is_id ? ID_VALUE : r_regs[w_index];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= StIdle;
      r_prdata  <= 32'h0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
`ifdef APB_SLAVE_WAIT_EN
      r_cnt     <= 4'd0;
`endif
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= 32'h0;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          r_prdata  <= 32'h0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          if (bus.PSEL && !bus.PENABLE) begin
`ifdef APB_SLAVE_WAIT_EN
            if (WAIT_CYCLES == 0) begin
              r_state   <= StReady;
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_rdata;
            end else begin
              r_state <= StWait;
              r_cnt   <= 4'(WAIT_CYCLES);
            end
`else
            r_state   <= StReady;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= w_rdata;
`endif
          end
        end
`ifdef APB_SLAVE_WAIT_EN
        StWait: begin
          if (!bus.PSEL) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state   <= StReady;
            r_cnt     <= 4'd0;
            r_pready  <= 1'b1;
            r_pslverr <= w_err;
            r_prdata  <= w_rdata;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`endif
        StReady: begin
          r_state   <= StIdle;
          r_prdata  <= 32'h0;
          r_pready  <= 1'b0;
          r_pslverr <= 1'b0;
          // An aborted transfer (PSEL low) must not commit.
          if (bus.PSEL && bus.PWRITE && !w_err) begin
            for (int i = 0; i < 4; i++) begin
              if (bus.PSTRB[i]) begin
                r_regs[w_index][8*i +: 8] <= bus.PWDATA[8*i +: 8];
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.PRDATA  = r_prdata;
  assign bus.PREADY  = r_pready;
  assign bus.PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave.sv
// Directed self-checking bench for apb_slave; expected latency follows APB_SLAVE_WAIT_EN.
module tb_apb_slave;

  localparam int unsigned WaitCycles = 2;
  localparam logic [31:0] IdValue    = 32'hA9B0_0001;
`ifdef APB_SLAVE_WAIT_EN
  localparam int ExpLat = WaitCycles + 1;
`else
  localparam int ExpLat = 1;
`endif
  localparam int MaxLat = 40;

  logic PCLK;
  logic PRESETn;
  int   n_checks;
  int   n_errors;

  apb_slave_if bus ();

  apb_slave #(
    .NUM_REGS   (16),
    .BASE_ADDR  (32'h0000_0000),
    .WAIT_CYCLES(WaitCycles),
    .ID_VALUE   (IdValue)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Drives one transfer starting just after a rising edge; returns the access cycle of PREADY.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int lat);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wd;
    bus.PSTRB   = st;
    rd  = 32'hX;
    err = 1'bX;
    lat = 0;
    @(posedge PCLK);
    #1 bus.PENABLE = 1'b1;
    forever begin
      lat++;
      @(negedge PCLK);
      if (bus.PREADY) begin
        rd  = bus.PRDATA;
        err = bus.PSLVERR;
        break;
      end
      if (lat >= MaxLat) break;
      @(posedge PCLK);
      #1;
    end
    @(posedge PCLK);
    #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    PRESETn     = 1'b0;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PADDR   = 32'h0;
    bus.PWRITE  = 1'b0;
    bus.PWDATA  = 32'h0;
    bus.PSTRB   = 4'h0;
    #12;
    n_checks++;
    if (bus.PREADY !== 1'b0) begin
      n_errors++; $display("FAIL reset_pready: got %b expected 0", bus.PREADY);
    end
    n_checks++;
    if (bus.PSLVERR !== 1'b0) begin
      n_errors++; $display("FAIL reset_pslverr: got %b expected 0", bus.PSLVERR);
    end
    n_checks++;
    if (bus.PRDATA !== 32'h0) begin
      n_errors++; $display("FAIL reset_prdata: got %h expected 0", bus.PRDATA);
    end
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_read_all();
    logic [31:0] rd; logic err; int lat;
    for (int a = 0; a < 15; a++) begin
      xfer(32'(a * 4), 1'b0, 32'h0, 4'h0, rd, err, lat);
      n_checks++;
      if (rd !== 32'h0 || err !== 1'b0 || lat != ExpLat) begin
        n_errors++;
        $display("FAIL read_reset_val addr %h: got rd=%h err=%b lat=%0d expected 0/0/%0d",
                 a * 4, rd, err, lat, ExpLat);
      end
    end
    xfer(32'h3C, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== IdValue || err !== 1'b0) begin
      n_errors++;
      $display("FAIL read_id: got rd=%h err=%b expected %h/0", rd, err, IdValue);
    end
  endtask

  task automatic test_strobe();
    logic [31:0] rd; logic err; int lat;
    xfer(32'h08, 1'b1, 32'hDEAD_BEEF, 4'b1111, rd, err, lat);
    n_checks++;
    if (err !== 1'b0 || lat != ExpLat) begin
      n_errors++; $display("FAIL write_full: got err=%b lat=%0d expected 0/%0d", err, lat, ExpLat);
    end
    xfer(32'h08, 1'b1, 32'h1122_3344, 4'b0101, rd, err, lat);
    xfer(32'h08, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'hDE22_BE44 || err !== 1'b0) begin
      n_errors++; $display("FAIL strobe_merge: got %h err=%b expected de22be44/0", rd, err);
    end
    xfer(32'h08, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, err, lat);
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++; $display("FAIL strobe_zero_err: got %b expected 0", err);
    end
    xfer(32'h08, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'hDE22_BE44) begin
      n_errors++; $display("FAIL strobe_zero_keep: got %h expected de22be44", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int lat;
    xfer(32'h40, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_errors++; $display("FAIL err_range: got rd=%h err=%b expected 0/1", rd, err);
    end
    xfer(32'h05, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'h0 || err !== 1'b1) begin
      n_errors++; $display("FAIL err_misaligned: got rd=%h err=%b expected 0/1", rd, err);
    end
    xfer(32'h0A, 1'b1, 32'h5555_5555, 4'hF, rd, err, lat);
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++; $display("FAIL err_misaligned_wr: got %b expected 1", err);
    end
    xfer(32'h08, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'hDE22_BE44) begin
      n_errors++; $display("FAIL err_no_change: got %h expected de22be44", rd);
    end
    xfer(32'h3C, 1'b1, 32'h0000_0001, 4'hF, rd, err, lat);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      n_errors++; $display("FAIL err_id_write: got rd=%h err=%b expected 0/1", rd, err);
    end
    xfer(32'h3C, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== IdValue || err !== 1'b0) begin
      n_errors++; $display("FAIL id_after_write: got %h err=%b expected %h/0", rd, err, IdValue);
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int lat; int pulses;
    xfer(32'h04, 1'b1, 32'h0000_5555, 4'hF, rd, err, lat);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = 32'h04;
    bus.PWRITE  = 1'b1;
    bus.PWDATA  = 32'h1234_5678;
    bus.PSTRB   = 4'hF;
    @(posedge PCLK);
    #1 bus.PENABLE = 1'b1;
    pulses = 0;
    @(negedge PCLK);
    if (bus.PREADY) pulses++;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    repeat (4) begin
      @(negedge PCLK);
      if (bus.PREADY) pulses++;
    end
    n_checks++;
    if (pulses != ((ExpLat == 1) ? 1 : 0)) begin
      n_errors++;
      $display("FAIL abort_pready: got %0d pulses expected %0d", pulses, (ExpLat == 1) ? 1 : 0);
    end
    @(posedge PCLK);
    #1;
    xfer(32'h04, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'h0000_5555) begin
      n_errors++; $display("FAIL abort_no_write: got %h expected 00005555", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic err; int lat;
    xfer(32'h0C, 1'b1, 32'hCAFE_F00D, 4'hF, rd, err, lat);
    xfer(32'h0C, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'hCAFE_F00D) begin
      n_errors++; $display("FAIL pre_reset_val: got %h expected cafef00d", rd);
    end
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = 32'h10;
    bus.PWRITE  = 1'b1;
    bus.PWDATA  = 32'h7777_7777;
    bus.PSTRB   = 4'hF;
    @(posedge PCLK);
    #1 bus.PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    n_checks++;
    if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.PRDATA !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_async: got pready=%b pslverr=%b prdata=%h expected 0/0/0",
               bus.PREADY, bus.PSLVERR, bus.PRDATA);
    end
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    xfer(32'h0C, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++; $display("FAIL reset_clears_0c: got %h expected 0", rd);
    end
    xfer(32'h10, 1'b0, 32'h0, 4'h0, rd, err, lat);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++; $display("FAIL reset_drops_wr_10: got %h expected 0", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat0; int lat1;
    xfer(32'h00, 1'b1, 32'hA5A5_0000, 4'hF, rd, err, lat0);
    xfer(32'h04, 1'b1, 32'h0000_5A5A, 4'hF, rd, err, lat1);
    n_checks++;
    if (lat0 != ExpLat || lat1 != ExpLat) begin
      n_errors++;
      $display("FAIL b2b_latency: got %0d/%0d expected %0d", lat0, lat1, ExpLat);
    end
    xfer(32'h00, 1'b0, 32'h0, 4'h0, rd, err, lat0);
    n_checks++;
    if (rd !== 32'hA5A5_0000) begin
      n_errors++; $display("FAIL b2b_read0: got %h expected a5a50000", rd);
    end
    xfer(32'h04, 1'b0, 32'h0, 4'h0, rd, err, lat0);
    n_checks++;
    if (rd !== 32'h0000_5A5A) begin
      n_errors++; $display("FAIL b2b_read4: got %h expected 00005a5a", rd);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_read_all();
    test_strobe();
    test_errors();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
